// File: rtl/sine_meas_pkg.sv
// Shared types and constants for the sine period / amplitude meter.
package sine_meas_pkg;

  localparam int unsigned DATA_W_DEF     = 16;
  localparam int unsigned CNT_W_DEF      = 32;
  localparam int unsigned CLK_HZ         = 10_000_000;
  localparam int unsigned HYST_DEF       = 256;
  // Signal is declared lost after 100 ms without a complete period.
  localparam int unsigned MAX_PERIOD_DEF = CLK_HZ / 10;

  typedef enum logic [1:0] {
    ST_INIT,
    ST_ARMED,
    ST_RUN,
    ST_RUN_NEG
  } meas_state_e;

  // Last region the signal was seen in outside the hysteresis band.
  typedef enum logic [1:0] {
    REG_NONE,
    REG_BELOW,
    REG_ABOVE
  } region_e;

endpackage

// File: rtl/sine_period_meter_if.sv
// Sample stream in, measurement results out.
interface sine_period_meter_if #(
  parameter int unsigned DATA_W = sine_meas_pkg::DATA_W_DEF,
  parameter int unsigned CNT_W  = sine_meas_pkg::CNT_W_DEF
);

  logic                     sample_en;
  logic signed [DATA_W-1:0] sin_val;
  logic [CNT_W-1:0]         period;
  logic [DATA_W-1:0]        amplitude;
  logic                     meas_valid;
  logic                     lost;

  modport master (
    output sample_en, sin_val,
    input  period, amplitude, meas_valid, lost
  );

  modport slave (
    input  sample_en, sin_val,
    output period, amplitude, meas_valid, lost
  );

endinterface

// File: rtl/sine_xing_det.sv
// Hysteresis crossing detector. The region history is registered; the
// crossing pulses are decoded against the live sample so the meter can act
// in the same cycle the crossing sample is presented.
module sine_xing_det #(
  parameter int unsigned DATA_W = sine_meas_pkg::DATA_W_DEF,
  parameter int unsigned HYST   = sine_meas_pkg::HYST_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     sample_en,
  input  logic signed [DATA_W-1:0] sin_val,
  output logic                     rise_x,
  output logic                     fall_x,
  output logic                     below
);

  import sine_meas_pkg::*;

  localparam logic signed [DATA_W-1:0] POS_TH = DATA_W'(HYST);
  localparam logic signed [DATA_W-1:0] NEG_TH = -POS_TH;

  region_e region;
  logic    above;

  assign above  = sample_en && (sin_val > POS_TH);
  assign below  = sample_en && (sin_val < NEG_TH);
  assign rise_x = above && (region == REG_BELOW);
  assign fall_x = below && (region == REG_ABOVE);

  // Remember the last out-of-band region; in-band samples leave it alone.
  always_ff @(posedge clk) begin
    if (reset) begin
      region <= REG_NONE;
    end else if (above) begin
      region <= REG_ABOVE;
    end else if (below) begin
      region <= REG_BELOW;
    end
  end

endmodule

// File: rtl/sine_period_meter.sv
// Measures period (clk cycles between rising crossings) and peak amplitude
// of a signed sample stream; flags loss of signal after MAX_PERIOD cycles.
module sine_period_meter
  import sine_meas_pkg::*;
#(
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned CNT_W      = CNT_W_DEF,
  parameter int unsigned HYST       = HYST_DEF,
  parameter int unsigned MAX_PERIOD = MAX_PERIOD_DEF
) (
  input logic                clk,
  input logic                reset,
  sine_period_meter_if.slave bus
);

  localparam logic [CNT_W-1:0]         MAX_CNT  = CNT_W'(MAX_PERIOD);
  localparam logic signed [DATA_W-1:0] MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic signed [DATA_W-1:0] MOST_POS = {1'b0, {(DATA_W-1){1'b1}}};

  meas_state_e              state;
  logic [CNT_W-1:0]         cnt;
  logic [CNT_W-1:0]         cnt_inc;
  logic                     timeout;
  logic signed [DATA_W-1:0] mx;
  logic signed [DATA_W-1:0] mn;
  logic signed [DATA_W-1:0] smp;
  logic                     smp_en;
  logic [DATA_W:0]          swing;
  logic [DATA_W-1:0]        half_swing;
  logic                     rise_x;
  logic                     fall_x;
  logic                     below;
  logic [CNT_W-1:0]         meas_period;
  logic [DATA_W-1:0]        meas_amp;
  logic                     valid_pulse;
  logic                     lost_flag;

  assign smp    = bus.sin_val;
  assign smp_en = bus.sample_en;

  assign bus.period     = meas_period;
  assign bus.amplitude  = meas_amp;
  assign bus.meas_valid = valid_pulse;
  assign bus.lost       = lost_flag;

  sine_xing_det #(
    .DATA_W (DATA_W),
    .HYST   (HYST)
  ) u_xing (
    .clk       (clk),
    .reset     (reset),
    .sample_en (smp_en),
    .sin_val   (smp),
    .rise_x    (rise_x),
    .fall_x    (fall_x),
    .below     (below)
  );

  // cnt_inc is the distance from the last crossing to the current sample.
  always_comb begin
    cnt_inc = (cnt >= MAX_CNT) ? MAX_CNT : cnt + CNT_W'(1);
    timeout = (cnt_inc >= MAX_CNT);
  end

  // Swing in one extra bit so a full-scale signal cannot wrap.
  always_comb begin
    swing      = {mx[DATA_W-1], mx} - {mn[DATA_W-1], mn};
    half_swing = swing[DATA_W:1];
  end

  // Measurement FSM with period counter, peak trackers and result registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_INIT;
      cnt         <= '0;
      mx          <= MOST_NEG;
      mn          <= MOST_POS;
      meas_period <= '0;
      meas_amp    <= '0;
      valid_pulse <= 1'b0;
      lost_flag   <= 1'b0;
    end else begin
      valid_pulse <= 1'b0;
      cnt         <= cnt_inc;
      case (state)
        ST_INIT: begin
          if (below) begin
            state <= ST_ARMED;
          end
        end
        ST_ARMED: begin
          if (rise_x) begin
            cnt   <= '0;
            mx    <= smp;
            mn    <= smp;
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (smp_en) begin
            if (smp > mx) mx <= smp;
            if (smp < mn) mn <= smp;
          end
          if (timeout) begin
            lost_flag <= 1'b1;
            mx        <= MOST_NEG;
            mn        <= MOST_POS;
            state     <= ST_INIT;
          end else if (fall_x) begin
            state <= ST_RUN_NEG;
          end
        end
        ST_RUN_NEG: begin
          if (rise_x) begin
            // A crossing in the timeout cycle still completes the period.
            meas_period <= cnt_inc;
            meas_amp    <= half_swing;
            valid_pulse <= 1'b1;
            lost_flag   <= 1'b0;
            cnt         <= '0;
            mx          <= smp;
            mn          <= smp;
            state       <= ST_RUN;
          end else if (timeout) begin
            lost_flag <= 1'b1;
            mx        <= MOST_NEG;
            mn        <= MOST_POS;
            state     <= ST_INIT;
          end else if (smp_en) begin
            if (smp > mx) mx <= smp;
            if (smp < mn) mn <= smp;
          end
        end
        default: begin
          state <= ST_INIT;
        end
      endcase
    end
  end

endmodule
